// File: rtl/frame_buffer_writer.sv
// Raster pixel stream to dual-port frame buffer writer with SOF lock, resync and done pulse.
// Optional binarisation of written pixels against THRESH when FBW_THRESHOLD_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a start pulse, stream not accepted
// WAIT_SOF | armed, dropping beats until one carries s_sof
// WRITE    | writing raster pixels, resync on a mid-frame s_sof
// DONE     | single cycle, frame_done asserted
module frame_buffer_writer #(
    parameter int          IMG_W  = 256,
    parameter int          IMG_H  = 256,
    parameter logic [7:0]  THRESH = 8'd64
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_sof,
    input  logic [7:0]  s_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        sof_err
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [15:0]   LINE_STEP = 16'(IMG_W);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SOF = 2'd1;
    localparam logic [1:0] S_WRITE    = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [15:0]   line_base;

    logic          accept;
    logic          take;
    logic          resync;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [15:0]   cur_base;
    logic          cur_last;
    logic [7:0]    pix_data;

    assign s_ready    = (state == S_WAIT_SOF) || (state == S_WRITE);
    assign busy       = s_ready;
    assign frame_done = (state == S_DONE);

    assign accept = s_valid && s_ready;
    assign take   = accept && (s_sof || (state == S_WRITE));
    assign resync = accept && s_sof && (state == S_WRITE);

    // A beat carrying s_sof is always pixel (0,0), whichever state accepted it.
    assign cur_col  = s_sof ? '0 : col;
    assign cur_row  = s_sof ? '0 : row;
    assign cur_base = s_sof ? 16'd0 : line_base;
    assign cur_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

`ifdef FBW_THRESHOLD_EN
    assign pix_data = (s_data >= THRESH) ? 8'hFF : 8'h00;
`else
    logic [7:0] thresh_unused;
    assign thresh_unused = THRESH;
    assign pix_data      = s_data;
`endif

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            line_base <= 16'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 16'd0;
            wr_data   <= 8'd0;
            sof_err   <= 1'b0;
        end else begin
            wr_en <= take;
            if (take) begin
                wr_addr <= cur_base + 16'(cur_col);
                wr_data <= pix_data;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WAIT_SOF;
                        sof_err   <= 1'b0;
                        col       <= '0;
                        row       <= '0;
                        line_base <= 16'd0;
                    end
                end
                S_WAIT_SOF, S_WRITE: begin
                    if (take) begin
                        if (resync)
                            sof_err <= 1'b1;
                        if (cur_col == COL_LAST) begin
                            col       <= '0;
                            row       <= cur_row + RW'(1);
                            line_base <= cur_base + LINE_STEP;
                        end else begin
                            col       <= cur_col + CW'(1);
                            row       <= cur_row;
                            line_base <= cur_base;
                        end
                        state <= cur_last ? S_DONE : S_WRITE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
